// File: rtl/vmicro16_apb_rr_arb.sv
// Round-robin APB arbiter: shares one downstream APB slave bus between
// MASTERS core-side APB masters, with a watchdog that terminates hung
// transfers and returns ERR_DATA to the stalled master.

// Per-master response steering: only the owning master sees PREADY/PRDATA.
module vmicro16_apb_rr_arb_rsp #(
  parameter int                    DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA   = 16'hDEAD
) (
  input  logic                  hit_i,
  input  logic                  tmo_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic                  pready_o,
  output logic [DATA_WIDTH-1:0] prdata_o
);
  assign pready_o = hit_i;
  assign prdata_o = !hit_i ? '0 : (tmo_i ? ERR_DATA : rdata_i);
endmodule

module vmicro16_apb_rr_arb #(
  parameter int                    MASTERS    = 4,
  parameter int                    BUS_WIDTH  = 20,
  parameter int                    DATA_WIDTH = 16,
  parameter int                    TIMEOUT    = 255,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA   = 16'hDEAD
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [MASTERS*BUS_WIDTH-1:0]     S_PADDR,
  input  logic [MASTERS-1:0]               S_PWRITE,
  input  logic [MASTERS-1:0]               S_PSELx,
  input  logic [MASTERS-1:0]               S_PENABLE,
  input  logic [MASTERS*DATA_WIDTH-1:0]    S_PWDATA,
  output logic [MASTERS*DATA_WIDTH-1:0]    S_PRDATA,
  output logic [MASTERS-1:0]               S_PREADY,
  output logic [BUS_WIDTH-1:0]             M_PADDR,
  output logic                             M_PWRITE,
  output logic                             M_PSEL,
  output logic                             M_PENABLE,
  output logic [DATA_WIDTH-1:0]            M_PWDATA,
  input  logic [DATA_WIDTH-1:0]            M_PRDATA,
  input  logic                             M_PREADY,
  output logic [$clog2(MASTERS)-1:0]       grant_id,
  output logic                             busy,
  output logic                             timeout
);
  localparam int IDW = $clog2(MASTERS);
  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e                 state_q, state_d;
  logic [IDW-1:0]         last_q, last_d;
  logic [IDW-1:0]         gid_q, gid_d;
  logic [BUS_WIDTH-1:0]   addr_q, addr_d;
  logic                   write_q, write_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [WDW-1:0]         wd_q, wd_d;

  logic [IDW-1:0]         win;
  logic                   done_c, tmo_c;

  // PENABLE from the masters carries no arbitration information.
  logic unused_penable;
  assign unused_penable = &{1'b0, S_PENABLE};

  // Packed per-master views of the flat request buses.
  logic [MASTERS-1:0][BUS_WIDTH-1:0]  paddr_v;
  logic [MASTERS-1:0][DATA_WIDTH-1:0] pwdata_v;
  assign paddr_v  = S_PADDR;
  assign pwdata_v = S_PWDATA;

  // Round-robin search: first set request starting just after the last owner.
  always_comb begin
    int idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    win   = last_q;
    for (int k = 1; k <= MASTERS; k++) begin
      idx = (int'(last_q) + k) % MASTERS;
      if (!found && S_PSELx[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  // Next-state and bus-phase decode for the IDLE/SETUP/ACCESS transfer FSM.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gid_d     = gid_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    wd_d      = wd_q;
    done_c    = 1'b0;
    tmo_c     = 1'b0;
    M_PSEL    = 1'b0;
    M_PENABLE = 1'b0;
    case (state_q)
      IDLE: begin
        if (|S_PSELx) begin
          state_d = SETUP;
          last_d  = win;
          gid_d   = win;
          addr_d  = paddr_v[win];
          write_d = S_PWRITE[win];
          wdata_d = pwdata_v[win];
          wd_d    = '0;
        end
      end
      SETUP: begin
        M_PSEL  = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        M_PSEL    = 1'b1;
        M_PENABLE = 1'b1;
        if (M_PREADY) begin
          done_c  = 1'b1;
          state_d = IDLE;
        end else if (wd_q == WDW'(TIMEOUT - 1)) begin
          done_c  = 1'b1;
          tmo_c   = 1'b1;
          state_d = IDLE;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, round-robin pointer, latched transfer and watchdog registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= IDW'(MASTERS - 1);
      gid_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      wd_q    <= wd_d;
    end
  end

  assign M_PADDR  = addr_q;
  assign M_PWRITE = write_q;
  assign M_PWDATA = wdata_q;
  assign grant_id = gid_q;
  assign busy     = (state_q != IDLE);
  assign timeout  = tmo_c;

  for (genvar i = 0; i < MASTERS; i++) begin : g_rsp
    vmicro16_apb_rr_arb_rsp #(
      .DATA_WIDTH (DATA_WIDTH),
      .ERR_DATA   (ERR_DATA)
    ) u_rsp (
      .hit_i    (done_c && (gid_q == IDW'(i))),
      .tmo_i    (tmo_c),
      .rdata_i  (M_PRDATA),
      .pready_o (S_PREADY[i]),
      .prdata_o (S_PRDATA[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_vmicro16_apb_rr_arb.sv
// Directed bench for vmicro16_apb_rr_arb: a per-cycle vector table for the
// single-read and round-robin scenarios, plus hand sequences for wait states,
// watchdog timeout, mid-transfer input changes and reset abort.
module tb_vmicro16_apb_rr_arb;
  localparam int M  = 4;
  localparam int AW = 20;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [M*AW-1:0] S_PADDR;
  logic [M-1:0]    S_PWRITE, S_PSELx, S_PENABLE;
  logic [M*DW-1:0] S_PWDATA, S_PRDATA;
  logic [M-1:0]    S_PREADY;
  logic [AW-1:0]   M_PADDR;
  logic            M_PWRITE, M_PSEL, M_PENABLE;
  logic [DW-1:0]   M_PWDATA, M_PRDATA;
  logic            M_PREADY;
  logic [1:0]      grant_id;
  logic            busy, timeout;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vmicro16_apb_rr_arb #(
    .MASTERS(M), .BUS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(4), .ERR_DATA(16'hDEAD)
  ) dut (
    .clk(clk), .reset(reset),
    .S_PADDR(S_PADDR), .S_PWRITE(S_PWRITE), .S_PSELx(S_PSELx),
    .S_PENABLE(S_PENABLE), .S_PWDATA(S_PWDATA), .S_PRDATA(S_PRDATA),
    .S_PREADY(S_PREADY), .M_PADDR(M_PADDR), .M_PWRITE(M_PWRITE),
    .M_PSEL(M_PSEL), .M_PENABLE(M_PENABLE), .M_PWDATA(M_PWDATA),
    .M_PRDATA(M_PRDATA), .M_PREADY(M_PREADY), .grant_id(grant_id),
    .busy(busy), .timeout(timeout)
  );

  typedef struct {
    logic          rst;
    logic [3:0]    psel;
    logic          mrdy;
    logic [15:0]   mrd;
    logic          msel, men;
    logic [3:0]    sp;
    logic [1:0]    gid;
    logic          bsy, tmo;
    logic [19:0]   maddr;
    logic [15:0]   erd;
  } vec_t;

  localparam int NV = 21;
  vec_t tv[NV];

  function automatic vec_t mk(input logic rst, input logic [3:0] psel, input logic mrdy,
                              input logic [15:0] mrd, input logic msel, input logic men,
                              input logic [3:0] sp, input logic [1:0] gid, input logic bsy,
                              input logic tmo, input logic [19:0] maddr, input logic [15:0] erd);
    vec_t v;
    v.rst = rst; v.psel = psel; v.mrdy = mrdy; v.mrd = mrd; v.msel = msel; v.men = men;
    v.sp = sp; v.gid = gid; v.bsy = bsy; v.tmo = tmo; v.maddr = maddr; v.erd = erd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    #4;
  endtask

  task automatic do_reset();
    next();
    reset = 1'b0; S_PSELx = '0; M_PREADY = 1'b0; S_PWRITE = '0;
    next();
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [127:0] exp_rd;
    reset = 1'b0; S_PSELx = '0; S_PENABLE = '0; S_PWRITE = '0; S_PWDATA = '0;
    M_PREADY = 1'b0; M_PRDATA = '0;
    S_PADDR = {20'h00300, 20'h00010, 20'h00200, 20'h00100};

    //           rst psel   rdy mrd       sel en sp     gid bsy tmo maddr     erd
    tv[0]  = mk(1, 4'b0000, 0, 16'h0000, 0, 0, 4'b0000, 0, 0, 0, 20'h00000, 16'h0);
    // single master 2 read, zero-wait slave
    tv[1]  = mk(0, 4'b0100, 1, 16'h1234, 0, 0, 4'b0000, 0, 0, 0, 20'h00000, 16'h0);
    tv[2]  = mk(0, 4'b0100, 1, 16'h1234, 1, 0, 4'b0000, 2, 1, 0, 20'h00010, 16'h0);
    tv[3]  = mk(0, 4'b0100, 1, 16'h1234, 1, 1, 4'b0100, 2, 1, 0, 20'h00010, 16'h1234);
    tv[4]  = mk(0, 4'b0000, 1, 16'h1234, 0, 0, 4'b0000, 2, 0, 0, 20'h00010, 16'h0);
    tv[5]  = mk(1, 4'b0000, 0, 16'h0000, 0, 0, 4'b0000, 0, 0, 0, 20'h00000, 16'h0);
    // all four request continuously: order 0,1,2,3,0
    tv[6]  = mk(0, 4'b1111, 1, 16'h5A5A, 0, 0, 4'b0000, 0, 0, 0, 20'h00000, 16'h0);
    tv[7]  = mk(0, 4'b1111, 1, 16'h5A5A, 1, 0, 4'b0000, 0, 1, 0, 20'h00100, 16'h0);
    tv[8]  = mk(0, 4'b1111, 1, 16'h5A5A, 1, 1, 4'b0001, 0, 1, 0, 20'h00100, 16'h5A5A);
    tv[9]  = mk(0, 4'b1111, 1, 16'h5A5A, 0, 0, 4'b0000, 0, 0, 0, 20'h00100, 16'h0);
    tv[10] = mk(0, 4'b1111, 1, 16'h5A5A, 1, 0, 4'b0000, 1, 1, 0, 20'h00200, 16'h0);
    tv[11] = mk(0, 4'b1111, 1, 16'h5A5A, 1, 1, 4'b0010, 1, 1, 0, 20'h00200, 16'h5A5A);
    tv[12] = mk(0, 4'b1111, 1, 16'h5A5A, 0, 0, 4'b0000, 1, 0, 0, 20'h00200, 16'h0);
    tv[13] = mk(0, 4'b1111, 1, 16'h5A5A, 1, 0, 4'b0000, 2, 1, 0, 20'h00010, 16'h0);
    tv[14] = mk(0, 4'b1111, 1, 16'h5A5A, 1, 1, 4'b0100, 2, 1, 0, 20'h00010, 16'h5A5A);
    tv[15] = mk(0, 4'b1111, 1, 16'h5A5A, 0, 0, 4'b0000, 2, 0, 0, 20'h00010, 16'h0);
    tv[16] = mk(0, 4'b1111, 1, 16'h5A5A, 1, 0, 4'b0000, 3, 1, 0, 20'h00300, 16'h0);
    tv[17] = mk(0, 4'b1111, 1, 16'h5A5A, 1, 1, 4'b1000, 3, 1, 0, 20'h00300, 16'h5A5A);
    tv[18] = mk(0, 4'b1111, 1, 16'h5A5A, 0, 0, 4'b0000, 3, 0, 0, 20'h00300, 16'h0);
    tv[19] = mk(0, 4'b1111, 1, 16'h5A5A, 1, 0, 4'b0000, 0, 1, 0, 20'h00100, 16'h0);
    tv[20] = mk(0, 4'b1111, 1, 16'h5A5A, 1, 1, 4'b0001, 0, 1, 0, 20'h00100, 16'h5A5A);

    for (int k = 0; k < NV; k++) begin
      next();
      reset = !tv[k].rst; S_PSELx = tv[k].psel; M_PREADY = tv[k].mrdy; M_PRDATA = tv[k].mrd;
      mid();
      chk($sformatf("vec%0d_ctrl", k),
          128'({M_PSEL, M_PENABLE, S_PREADY, grant_id, busy, timeout}),
          128'({tv[k].msel, tv[k].men, tv[k].sp, tv[k].gid, tv[k].bsy, tv[k].tmo}));
      exp_rd = '0;
      for (int i = 0; i < M; i++) if (tv[k].sp[i]) exp_rd[i*DW +: DW] = tv[k].erd;
      chk($sformatf("vec%0d_prdata", k), 128'(S_PRDATA), exp_rd);
      chk($sformatf("vec%0d_maddr", k), 128'(M_PADDR), 128'(tv[k].maddr));
    end

    // master 1 write with three slave wait states
    do_reset();
    S_PSELx = 4'b0010; S_PWRITE = 4'b0010; S_PWDATA[16 +: 16] = 16'hBEEF; M_PRDATA = '0;
    next(); mid();
    chk("wr_setup", 128'({M_PSEL, M_PENABLE, M_PWRITE, M_PWDATA}), 128'({2'b10, 1'b1, 16'hBEEF}));
    for (int a = 1; a <= 3; a++) begin
      next(); mid();
      chk($sformatf("wr_wait%0d", a), 128'({M_PENABLE, S_PREADY, timeout, M_PWDATA}),
          128'({1'b1, 4'b0000, 1'b0, 16'hBEEF}));
    end
    next(); M_PREADY = 1'b1; mid();
    chk("wr_done", 128'({M_PENABLE, S_PREADY, timeout, M_PWDATA, M_PWRITE}),
        128'({1'b1, 4'b0010, 1'b0, 16'hBEEF, 1'b1}));
    next(); S_PSELx = '0; M_PREADY = 1'b0; S_PWRITE = '0; mid();
    chk("wr_idle", 128'({busy, S_PREADY}), 128'(0));

    // watchdog: master 0 times out, then master 2 is served
    do_reset();
    S_PSELx = 4'b0101; M_PRDATA = 16'h7777;
    next(); mid();
    chk("to_grant", 128'({M_PSEL, grant_id}), 128'({1'b1, 2'd0}));
    for (int a = 1; a <= 3; a++) begin
      next(); mid();
      chk($sformatf("to_wait%0d", a), 128'({M_PENABLE, S_PREADY, timeout}), 128'({1'b1, 4'b0000, 1'b0}));
    end
    next(); mid();
    chk("to_fire", 128'({S_PREADY, timeout}), 128'({4'b0001, 1'b1}));
    chk("to_errdata", 128'(S_PRDATA), 128'(64'h0000_0000_0000_DEAD));
    next(); S_PSELx = 4'b0100; mid();
    chk("to_idle", 128'({busy, timeout, S_PREADY}), 128'(0));
    next(); mid();
    chk("to_next_grant", 128'({M_PSEL, grant_id}), 128'({1'b1, 2'd2}));
    next(); M_PREADY = 1'b1; mid();
    chk("to_next_done", 128'({S_PREADY, timeout, S_PRDATA}), 128'({4'b0100, 1'b0, 64'h0000_7777_0000_0000}));
    next(); S_PSELx = '0; M_PREADY = 1'b0;

    // master 3 changes address and drops select during SETUP
    do_reset();
    S_PSELx = 4'b1000;
    next(); S_PSELx = '0; S_PADDR[60 +: 20] = 20'hFFFFF; mid();
    chk("hold_setup_addr", 128'({M_PSEL, M_PADDR}), 128'({1'b1, 20'h00300}));
    next(); M_PREADY = 1'b1; M_PRDATA = 16'h4242; mid();
    chk("hold_access_addr", 128'(M_PADDR), 128'(20'h00300));
    chk("hold_done", 128'({S_PREADY, S_PRDATA}), 128'({4'b1000, 64'h4242_0000_0000_0000}));
    next(); S_PADDR[60 +: 20] = 20'h00300; M_PREADY = 1'b0;

    // reset during ACCESS aborts; afterwards master 0 wins over master 2
    do_reset();
    S_PSELx = 4'b0001; S_PWRITE = 4'b0001; S_PWDATA[0 +: 16] = 16'h1111;
    next(); next(); mid();
    chk("rst_in_access", 128'({M_PSEL, M_PENABLE, M_PWRITE}), 128'(3'b111));
    #1 reset = 1'b0;
    #1;
    chk("rst_all_zero", 128'({M_PSEL, M_PENABLE, M_PADDR, M_PWRITE, M_PWDATA, S_PREADY,
                              S_PRDATA, grant_id, busy, timeout}), 128'(0));
    next(); reset = 1'b1; S_PSELx = 4'b0101; S_PWRITE = '0;
    next(); mid();
    chk("rst_regrant", 128'({M_PSEL, grant_id, M_PADDR}), 128'({1'b1, 2'd0, 20'h00100}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
